// File: rtl/sha256_pkg.sv
// sha256_pkg: digest sizing and serializer state encoding shared with the sha256 core.
package sha256_pkg;
  localparam int DIGEST_W = 256;
  localparam int DIGEST_BYTES = DIGEST_W / 8;
  typedef enum logic {S_IDLE, S_SEND} ser_state_t;
endpackage

// File: rtl/sha256_digest_serializer.sv
// sha256_digest_serializer: captures a digest on hash_valid_in and streams it out as bytes over valid/ready.
module sha256_digest_serializer
  import sha256_pkg::*;
#(
  parameter int DIGEST_W  = sha256_pkg::DIGEST_W,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                enable,
  input  logic [DIGEST_W-1:0] hash_in,
  input  logic                hash_valid_in,
  output logic [7:0]          byte_out,
  output logic                byte_valid,
  input  logic                byte_ready,
  output logic                last_byte,
  output logic                busy,
  output logic                overrun,
  input  logic                clear_overrun
);
  localparam int NB = DIGEST_W / 8;
  localparam int CW = NB > 1 ? $clog2(NB) : 1;
  localparam logic [CW-1:0] LAST = CW'(NB - 1);

  ser_state_t          state_q, state_d;
  logic [DIGEST_W-1:0] sh_q, sh_d, shifted;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [7:0]          byte_out_q, byte_out_d;
  logic                byte_valid_q, byte_valid_d;
  logic                last_byte_q, last_byte_d;
  logic                busy_q, busy_d;
  logic                overrun_q, overrun_d;
  logic                cap, xfer, fin;

  always_comb begin
    cap     = enable && hash_valid_in;
    xfer    = state_q == S_SEND && byte_ready;
    fin     = xfer && cnt_q == LAST;
    shifted = MSB_FIRST ? sh_q << 8 : sh_q >> 8;
    state_d = state_q;
    sh_d    = sh_q;
    cnt_d   = cnt_q;
    // A capture on the final transfer edge chains straight into the next digest.
    if ((state_q == S_IDLE || fin) && cap) begin
      sh_d    = hash_in;
      cnt_d   = '0;
      state_d = S_SEND;
    end else if (fin) begin
      sh_d    = shifted;
      cnt_d   = '0;
      state_d = S_IDLE;
    end else if (xfer) begin
      sh_d  = shifted;
      cnt_d = cnt_q + 1'b1;
    end
    overrun_d    = (cap && state_q == S_SEND && !fin) || (overrun_q && !clear_overrun);
    byte_valid_d = state_d == S_SEND;
    busy_d       = state_d == S_SEND;
    last_byte_d  = byte_valid_d && cnt_d == LAST;
    byte_out_d   = byte_valid_d ? (MSB_FIRST ? sh_d[DIGEST_W-1 -: 8] : sh_d[7:0]) : 8'h00;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      sh_q         <= '0;
      cnt_q        <= '0;
      byte_out_q   <= '0;
      byte_valid_q <= 1'b0;
      last_byte_q  <= 1'b0;
      busy_q       <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      sh_q         <= sh_d;
      cnt_q        <= cnt_d;
      byte_out_q   <= byte_out_d;
      byte_valid_q <= byte_valid_d;
      last_byte_q  <= last_byte_d;
      busy_q       <= busy_d;
      overrun_q    <= overrun_d;
    end
  end

  assign byte_out   = byte_out_q;
  assign byte_valid = byte_valid_q;
  assign last_byte  = last_byte_q;
  assign busy       = busy_q;
  assign overrun    = overrun_q;
endmodule

// File: doc/sha256_digest_serializer.md
Name: sha256_digest_serializer

Overview:
Output-side companion to the sha256 core. It captures the 256-bit digest on the core's one-cycle hash_valid pulse and streams it out as 32 bytes over a valid/ready byte interface toward a UART or host FIFO. It is the byte-stream transmitter mirroring the core's byte-stream receive side. It flags digests that arrive while a previous digest is still streaming.

Parameters:
DIGEST_W, 256, digest width in bits; must be a multiple of 8.
MSB_FIRST, 1, 1 = emit hash_in[DIGEST_W-1 -: 8] first (standard hex order); 0 = emit hash_in[7:0] first.

Ports:
clk            input   1         system clock, rising edge
rst_n          input   1         asynchronous active-low reset
enable         input   1         gates digest capture only
hash_in        input   DIGEST_W  digest from sha256 hash_out
hash_valid_in  input   1         one-cycle capture strobe (sha256 hash_valid)
byte_out       output  8         current output byte
byte_valid     output  1         byte_out is valid
byte_ready     input   1         downstream accepts byte_out when high with byte_valid
last_byte      output  1         high with byte_valid on the final byte of a digest
busy           output  1         digest held or streaming (state != S_IDLE)
overrun        output  1         sticky: a digest was dropped
clear_overrun  input   1         synchronous clear of overrun

Behaviour:
- Interface fixed: one clock, clk; reset rst_n is asynchronous, active-low.
- Reset (asynchronous, immediate): byte_out=0, byte_valid=0, last_byte=0, busy=0, overrun=0, shift register=0, byte counter=0, state=S_IDLE. Reset mid-stream abandons the digest with no partial completion.
- FSM states:
  - S_IDLE: byte_valid=0. When hash_valid_in && enable, the next edge loads the shift register with hash_in, sets count=0 and moves to S_SEND.
  - S_SEND: byte_valid=1.
- Latency: first byte_valid is asserted the cycle after the capture strobe.
- Handshake: a transfer occurs on an edge where byte_valid && byte_ready.
  - On each transfer: shift the register by 8 toward the emit end and increment count.
  - While byte_valid && !byte_ready: byte_out, last_byte and byte_valid must hold stable.
- Counter: 5 bits for DIGEST_W=256 (width is $clog2(DIGEST_W/8)). last_byte = (state==S_SEND) && (count==DIGEST_W/8-1).
- Final transfer: the last-byte transfer returns the FSM to S_IDLE, and byte_valid drops the next cycle, unless a back-to-back capture occurs.
- Back-to-back capture: if hash_valid_in && enable on the same edge as the last-byte transfer:
  - the new digest is loaded, count=0, and the FSM stays in S_SEND;
  - the first byte of the new digest is presented the next cycle with no bubble;
  - no overrun is flagged.
- Overrun: hash_valid_in && enable in S_SEND, other than on the last-byte transfer edge:
  - the new digest is dropped and the current stream is unaffected;
  - overrun is set to 1 on the next edge.
- clear_overrun: clears overrun on the next edge. If a set event and clear_overrun coincide, set wins.
- enable=0: hash_valid_in is ignored and no overrun is flagged. An in-progress stream continues to completion.
- MSB_FIRST=0: byte_out is taken from the low end of the register and the shift is toward the LSB.
- byte_out shows the current emit-end byte while in S_SEND. It is don't-care in S_IDLE but is driven to 0 there.

Decomposition:
- sha256_pkg (shared with the core) holds:
  - localparam DIGEST_W=256 and DIGEST_BYTES=DIGEST_W/8;
  - typedef enum logic {S_IDLE, S_SEND} ser_state_t.
- No sub-module: a single shift register, counter and 2-state FSM (about 150 lines).

Test Plan:
1. Digest of "abc" (ba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad), byte_ready=1:
   - bytes ba,78,16,bf,…,15,ad appear on 32 consecutive cycles starting 1 cycle after the strobe;
   - last_byte only on 0xad;
   - busy drops after the final transfer.
2. Same digest with byte_ready alternating 1,0 (and a random-stall variant): identical 32-byte sequence; byte_out/byte_valid/last_byte stable on every stalled cycle; 63 cycles total with the alternating pattern.
3. Second strobe (digest 0x00…01) during byte 10:
   - overrun=1 the next cycle;
   - the stream still completes with the "abc" bytes;
   - pulsing clear_overrun gives overrun=0;
   - clear_overrun coincident with a new overrun event leaves overrun=1.
4. Strobe coincident with the last-byte transfer of the "abc" digest: the next cycle shows 0xe3 (first byte of the empty-message digest e3b0c442…b855) with byte_valid held high throughout and overrun=0.
5. Edge and reset cases:
   - rst_n asserted at byte 5: all outputs read 0 before the next edge;
   - after release, a new strobe streams from byte 0;
   - enable=0 with a strobe in S_IDLE: no capture, no overrun.
6. MSB_FIRST=0 with the "abc" digest: byte order ad,15,00,f2,…,ba; last_byte on 0xba.
